// File: rtl/btn_press_classifier.sv
// Debounces a bouncy push-button and classifies each press as short or long.
// Define BTN_AUTO_REPEAT_EN to add periodic repeat_pulse events during a long hold.
module btn_press_classifier #(
    parameter int DEBOUNCE_CYCLES   = 125000,
    parameter int LONG_PRESS_CYCLES = 125000000,
    parameter int REPEAT_CYCLES     = 25000000
) (
    input  logic clk,
    input  logic reset_p,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    logic              r_sync_p0;
    logic              r_sync_p1;
    logic              w_btn_s;
    logic              w_differs;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_btn_level;
    logic              r_press;
    logic              r_release;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_hold_last;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_short;
    logic              w_long;
    logic              w_repeat;

    // Stage p0/p1: two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= btn_raw;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign w_btn_s   = r_sync_p1;
    assign w_differs = (w_btn_s != r_btn_level);

    // Debounce: accept a level only after it differs for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_db_cnt    <= '0;
            r_btn_level <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (!w_differs) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt    <= '0;
                r_btn_level <= w_btn_s;
                r_press     <= w_btn_s;
                r_release   <= ~w_btn_s;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_hold_last = (r_hold_cnt == HOLD_LAST);

    // Hold counter stops at the threshold because HELD is left on that cycle
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_IDLE && r_press) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_HELD && !w_hold_last) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             w_rep_last;

    assign w_rep_last = (r_rep_cnt == REP_LAST);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_rep_cnt <= '0;
        end else if (w_long) begin
            r_rep_cnt <= '0;
        end else if (r_state == ST_LONG) begin
            r_rep_cnt <= w_rep_last ? '0 : r_rep_cnt + 1'b1;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; a release always takes priority over the long threshold
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_press) begin
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (r_release) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_hold_last) begin
                    w_state_nxt = ST_LONG;
                end
            end
            ST_LONG: begin
                if (r_release) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: classification pulses are mutually exclusive by construction
    always_comb begin
        w_short  = 1'b0;
        w_long   = 1'b0;
        w_repeat = 1'b0;
        case (r_state)
            ST_HELD: begin
                w_short = r_release;
                w_long  = w_hold_last & ~r_release;
            end
            ST_LONG: begin
`ifdef BTN_AUTO_REPEAT_EN
                w_repeat = w_rep_last & ~r_release;
`endif
            end
            default: ;
        endcase
    end

    assign btn_level     = r_btn_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign short_pulse   = w_short;
    assign long_pulse    = w_long;
`ifdef BTN_AUTO_REPEAT_EN
    assign repeat_pulse  = w_repeat;
`else
    assign repeat_pulse  = 1'b0;
`endif

endmodule
